// File: rtl/sram_responder_pkg.sv
// sram_pkg: shared types and constants for the SRAM responder slice.
//   state_t      : responder FSM states (IDLE, RD_WAIT, RD_DRIVE)
//   SRAM_DATA_W  : data bus width of the SRAM interface
//   SRAM_ADDR_W  : address bus width of the SRAM interface
//   LANE_LO/HI   : byte-lane indices into two-bit lane vectors
//   WAIT_W       : width of the read wait-cycle counter
package sram_pkg;

  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned LANE_LO     = 0;
  localparam int unsigned LANE_HI     = 1;
  localparam int unsigned WAIT_W      = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/sram_responder_byte_array.sv
// sram_byte_array: 2^MEM_W x 16-bit storage split into two byte lanes.
//   clk   : write clock
//   we    : per-lane write enables, indexed by LANE_LO / LANE_HI
//   waddr : write word address
//   wdata : write data
//   raddr : asynchronous read word address
//   rdata : asynchronous read data
// Contents are never reset.
module sram_byte_array
  import sram_pkg::*;
#(
  parameter int unsigned MEM_W = 12
) (
  input  logic                   clk,
  input  logic [1:0]             we,
  input  logic [MEM_W-1:0]       waddr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic [MEM_W-1:0]       raddr,
  output logic [SRAM_DATA_W-1:0] rdata
);

  logic [7:0] lo_mem [2**MEM_W];
  logic [7:0] hi_mem [2**MEM_W];

  always_ff @(posedge clk) begin
    if (we[LANE_LO]) lo_mem[waddr] <= wdata[7:0];
    if (we[LANE_HI]) hi_mem[waddr] <= wdata[15:8];
  end

  assign rdata = {hi_mem[raddr], lo_mem[raddr]};

endmodule

// File: rtl/sram_responder.sv
// sram_responder: far-end model of a 16-bit asynchronous-style SRAM.
// Stores byte-lane writes, answers reads after READ_LAT cycles, counts
// accesses and optionally flags protocol violations.
//   clk          : system clock, all logic on posedge
//   reset        : synchronous active-low reset
//   SRAM_CE_N    : chip enable (active low)
//   SRAM_WE_N    : write enable (active low), wins over SRAM_OE_N
//   SRAM_OE_N    : output enable (active low)
//   SRAM_UB_N    : upper byte lane [15:8] enable (active low)
//   SRAM_LB_N    : lower byte lane [7:0] enable (active low)
//   SRAM_ADDR    : word address, bits above MEM_W alias
//   SRAM_DQ      : bidirectional data, driven only from registers
//   access_cnt   : writes plus read data phases, wraps
//   protocol_err : sticky violation flag
// Build option: define SRAM_RESPONDER_PROTOCOL_CHECK_EN to compile in the
// protocol checker; otherwise protocol_err is tied low.
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned MEM_W    = 12,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [CNT_W-1:0]  access_cnt,
  output logic              protocol_err
);

  localparam logic [WAIT_W-1:0] LAT_RELOAD = WAIT_W'(READ_LAT - 1);

  state_t                   state_q, state_d;
  logic [WAIT_W-1:0]        wait_q, wait_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [1:0]               lane_en_q, lane_en_d;
  logic [SRAM_DATA_W-1:0]   data_q, data_d;
  logic [SRAM_DATA_W-1:0]   mem_rdata;
  logic                     cnt_inc;
  logic                     wr_req, rd_req, addr_same;
  logic                     start, enter;
  logic [1:0]               lanes_req;
  logic [1:0]               mem_we;

  assign wr_req    = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_req    = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign addr_same = (SRAM_ADDR == addr_q);
  assign lanes_req = {!SRAM_UB_N, !SRAM_LB_N};
  assign mem_we    = {wr_req && !SRAM_UB_N, wr_req && !SRAM_LB_N};

  // Read port follows the live address: at every drive entry the live
  // address equals the (about to be) latched address.
  sram_byte_array #(
    .MEM_W (MEM_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (SRAM_ADDR[MEM_W-1:0]),
    .wdata (SRAM_DQ),
    .raddr (SRAM_ADDR[MEM_W-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      addr_q     <= '0;
      lane_en_q  <= '0;
      data_q     <= '0;
      access_cnt <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      lane_en_q  <= lane_en_d;
      data_q     <= data_d;
      if (cnt_inc) access_cnt <= access_cnt + 1'b1;
    end
  end

  // start: (re)latch an address and begin the wait phase.
  // enter: take data and lane masks, begin driving, count the access.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    addr_d    = addr_q;
    lane_en_d = lane_en_q;
    data_d    = data_q;
    start     = 1'b0;
    enter     = 1'b0;

    if (wr_req) begin
      state_d   = IDLE;
      lane_en_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          lane_en_d = '0;
          if (rd_req) start = 1'b1;
        end
        RD_WAIT: begin
          if (!rd_req) begin
            state_d   = IDLE;
            lane_en_d = '0;
          end else if (!addr_same) begin
            start = 1'b1;
          end else if (wait_q <= WAIT_W'(1)) begin
            enter = 1'b1;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        RD_DRIVE: begin
          if (!rd_req) begin
            state_d   = IDLE;
            lane_en_d = '0;
          end else if (!addr_same) begin
            start = 1'b1;
          end else begin
            lane_en_d = lanes_req;
          end
        end
        default: begin
          state_d   = IDLE;
          lane_en_d = '0;
        end
      endcase
    end

    if (start) begin
      addr_d = SRAM_ADDR;
      if (READ_LAT == 1) begin
        enter = 1'b1;
      end else begin
        state_d   = RD_WAIT;
        wait_d    = LAT_RELOAD;
        lane_en_d = '0;
      end
    end

    if (enter) begin
      state_d   = RD_DRIVE;
      lane_en_d = lanes_req;
      data_d    = mem_rdata;
    end

    cnt_inc = wr_req || enter;
  end

  assign SRAM_DQ[7:0]  = lane_en_q[LANE_LO] ? data_q[7:0]  : 8'bz;
  assign SRAM_DQ[15:8] = lane_en_q[LANE_HI] ? data_q[15:8] : 8'bz;

`ifdef SRAM_RESPONDER_PROTOCOL_CHECK_EN
  logic              we_held_q;
  logic [ADDR_W-1:0] prev_addr_q;
  logic              err_q;
  logic              ctrl_unknown;
  logic              viol;

  always_comb begin
    ctrl_unknown = 1'b0;
`ifndef SYNTHESIS
    ctrl_unknown = $isunknown({SRAM_CE_N, SRAM_WE_N, SRAM_OE_N,
                               SRAM_UB_N, SRAM_LB_N});
`endif
  end

  assign viol = (wr_req && !SRAM_OE_N)
             || (wr_req && SRAM_UB_N && SRAM_LB_N)
             || (wr_req && we_held_q && (SRAM_ADDR != prev_addr_q))
             || ctrl_unknown;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q       <= 1'b0;
      we_held_q   <= 1'b0;
      prev_addr_q <= '0;
    end else begin
      if (viol) err_q <= 1'b1;
      we_held_q   <= wr_req;
      prev_addr_q <= SRAM_ADDR;
    end
  end

  assign protocol_err = err_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed self-checking bench for sram_responder.
// Two responders (READ_LAT=2 and READ_LAT=3) share the control inputs and
// each has its own data bus; the bench drives both buses during writes.
module tb_sram_responder;

`ifdef SRAM_RESPONDER_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_n, we_n, oe_n, ub_n, lb_n;
  logic [17:0] addr;
  logic [15:0] dq_wr;
  logic        dq_oe;
  wire  [15:0] dq2, dq3;
  logic [31:0] cnt2, cnt3;
  logic        perr2, perr3;
  int          checks = 0;
  int          errors = 0;

  assign dq2 = dq_oe ? dq_wr : 16'hzzzz;
  assign dq3 = dq_oe ? dq_wr : 16'hzzzz;

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(18), .MEM_W(12), .READ_LAT(2), .CNT_W(32)) dut2 (
    .clk(clk), .reset(reset), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_ADDR(addr), .SRAM_DQ(dq2), .access_cnt(cnt2), .protocol_err(perr2)
  );

  sram_responder #(.ADDR_W(18), .MEM_W(12), .READ_LAT(3), .CNT_W(32)) dut3 (
    .clk(clk), .reset(reset), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_ADDR(addr), .SRAM_DQ(dq3), .access_cnt(cnt3), .protocol_err(perr3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0;
    dq_oe = 1'b0;
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d,
                    input logic ub, input logic lb);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    ub_n = ub; lb_n = lb; addr = a;
    dq_wr = d; dq_oe = 1'b1;
    tick();
    idle();
    tick();
  endtask

  task automatic rd(input logic [17:0] a);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    ub_n = 1'b0; lb_n = 1'b0; addr = a;
    dq_oe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; dq_wr = '0; dq_oe = 1'b0;
    rd(18'h0);
    tick(); tick();
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL reset_dq_z: observed=%h expected=%h", dq2, 16'hzzzz); end
    checks++; if (cnt2 !== 32'd0) begin errors++; $error("FAIL reset_cnt2: observed=%h expected=%h", cnt2, 32'd0); end
    checks++; if (cnt3 !== 32'd0) begin errors++; $error("FAIL reset_cnt3: observed=%h expected=%h", cnt3, 32'd0); end
    checks++; if (perr2 !== 1'b0) begin errors++; $error("FAIL reset_perr: observed=%h expected=%h", perr2, 1'b0); end

    reset = 1'b1;
    tick();
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL rel_wait_z: observed=%h expected=%h", dq2, 16'hzzzz); end
    checks++; if (cnt2 !== 32'd0) begin errors++; $error("FAIL rel_wait_cnt: observed=%h expected=%h", cnt2, 32'd0); end
    tick();
    checks++; if (cnt2 !== 32'd1) begin errors++; $error("FAIL rel_drive_cnt: observed=%h expected=%h", cnt2, 32'd1); end
    checks++; if (cnt3 !== 32'd0) begin errors++; $error("FAIL rel_cnt3: observed=%h expected=%h", cnt3, 32'd0); end

    reset = 1'b0;
    tick();
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL midread_rst_z: observed=%h expected=%h", dq2, 16'hzzzz); end
    checks++; if (cnt2 !== 32'd0) begin errors++; $error("FAIL midread_rst_cnt: observed=%h expected=%h", cnt2, 32'd0); end
    reset = 1'b1;
    idle();
    tick();

    wr(18'h00005, 16'hBEEF, 1'b0, 1'b0);
    rd(18'h00005);
    tick();
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL rd_lat_z: observed=%h expected=%h", dq2, 16'hzzzz); end
    tick();
    checks++; if (dq2 !== 16'hBEEF) begin errors++; $error("FAIL rd_data: observed=%h expected=%h", dq2, 16'hBEEF); end
    checks++; if (cnt2 !== 32'd2) begin errors++; $error("FAIL rd_cnt: observed=%h expected=%h", cnt2, 32'd2); end
    tick();
    checks++; if (dq2 !== 16'hBEEF) begin errors++; $error("FAIL rd_hold: observed=%h expected=%h", dq2, 16'hBEEF); end
    checks++; if (cnt2 !== 32'd2) begin errors++; $error("FAIL rd_hold_cnt: observed=%h expected=%h", cnt2, 32'd2); end
    checks++; if (dq3 !== 16'hBEEF) begin errors++; $error("FAIL rd3_data: observed=%h expected=%h", dq3, 16'hBEEF); end
    checks++; if (cnt3 !== 32'd2) begin errors++; $error("FAIL rd3_cnt: observed=%h expected=%h", cnt3, 32'd2); end
    idle();
    tick();
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL rd_abort_z: observed=%h expected=%h", dq2, 16'hzzzz); end

    wr(18'h00007, 16'h1234, 1'b0, 1'b0);
    wr(18'h00007, 16'hAB00, 1'b0, 1'b1);
    rd(18'h00007);
    tick(); tick();
    checks++; if (dq2 !== 16'hAB34) begin errors++; $error("FAIL lane_merge: observed=%h expected=%h", dq2, 16'hAB34); end
    checks++; if (cnt2 !== 32'd5) begin errors++; $error("FAIL lane_cnt: observed=%h expected=%h", cnt2, 32'd5); end
    ub_n = 1'b1;
    tick();
    checks++; if (dq2[15:8] !== 8'hzz) begin errors++; $error("FAIL lane_hi_z: observed=%h expected=%h", dq2[15:8], 8'hzz); end
    checks++; if (dq2[7:0] !== 8'h34) begin errors++; $error("FAIL lane_lo_val: observed=%h expected=%h", dq2[7:0], 8'h34); end
    checks++; if (dq3[15:8] !== 8'hzz) begin errors++; $error("FAIL lane3_hi_z: observed=%h expected=%h", dq3[15:8], 8'hzz); end
    checks++; if (dq3[7:0] !== 8'h34) begin errors++; $error("FAIL lane3_lo_val: observed=%h expected=%h", dq3[7:0], 8'h34); end
    checks++; if (cnt3 !== 32'd5) begin errors++; $error("FAIL lane3_cnt: observed=%h expected=%h", cnt3, 32'd5); end
    idle();
    tick();

    wr(18'h00001, 16'h1111, 1'b0, 1'b0);
    wr(18'h00002, 16'h2222, 1'b0, 1'b0);
    rd(18'h00001);
    tick();
    addr = 18'h00002;
    tick();
    checks++; if (dq3 !== 16'hzzzz) begin errors++; $error("FAIL chg_z1: observed=%h expected=%h", dq3, 16'hzzzz); end
    tick();
    checks++; if (dq3 !== 16'hzzzz) begin errors++; $error("FAIL chg_z2: observed=%h expected=%h", dq3, 16'hzzzz); end
    checks++; if (dq2 !== 16'h2222) begin errors++; $error("FAIL chg2_data: observed=%h expected=%h", dq2, 16'h2222); end
    checks++; if (cnt2 !== 32'd8) begin errors++; $error("FAIL chg2_cnt: observed=%h expected=%h", cnt2, 32'd8); end
    tick();
    checks++; if (dq3 !== 16'h2222) begin errors++; $error("FAIL chg3_data: observed=%h expected=%h", dq3, 16'h2222); end
    checks++; if (cnt3 !== 32'd8) begin errors++; $error("FAIL chg3_cnt: observed=%h expected=%h", cnt3, 32'd8); end
    addr = 18'h00001;
    tick();
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL drvchg_z: observed=%h expected=%h", dq2, 16'hzzzz); end
    tick();
    checks++; if (dq2 !== 16'h1111) begin errors++; $error("FAIL drvchg_data: observed=%h expected=%h", dq2, 16'h1111); end
    checks++; if (cnt2 !== 32'd9) begin errors++; $error("FAIL drvchg_cnt: observed=%h expected=%h", cnt2, 32'd9); end
    idle();
    tick();

    rd(18'h00005);
    tick();
    oe_n = 1'b1;
    tick();
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL abort_z1: observed=%h expected=%h", dq2, 16'hzzzz); end
    tick();
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL abort_z2: observed=%h expected=%h", dq2, 16'hzzzz); end
    checks++; if (cnt2 !== 32'd9) begin errors++; $error("FAIL abort_cnt2: observed=%h expected=%h", cnt2, 32'd9); end
    checks++; if (cnt3 !== 32'd8) begin errors++; $error("FAIL abort_cnt3: observed=%h expected=%h", cnt3, 32'd8); end
    idle();
    tick();

    wr(18'h01005, 16'hCAFE, 1'b0, 1'b0);
    rd(18'h00005);
    tick(); tick();
    checks++; if (dq2 !== 16'hCAFE) begin errors++; $error("FAIL alias_data: observed=%h expected=%h", dq2, 16'hCAFE); end
    checks++; if (cnt2 !== 32'd11) begin errors++; $error("FAIL alias_cnt: observed=%h expected=%h", cnt2, 32'd11); end
    idle();
    tick();
    checks++; if (cnt3 !== 32'd9) begin errors++; $error("FAIL alias_cnt3: observed=%h expected=%h", cnt3, 32'd9); end
    checks++; if (perr2 !== 1'b0) begin errors++; $error("FAIL pre_chk_perr: observed=%h expected=%h", perr2, 1'b0); end

    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; ub_n = 1'b0; lb_n = 1'b0;
    addr = 18'h00009; dq_wr = 16'h5555; dq_oe = 1'b1;
    tick();
    checks++; if (perr2 !== EXP_ERR) begin errors++; $error("FAIL perr_set: observed=%h expected=%h", perr2, EXP_ERR); end
    idle();
    tick();
    checks++; if (perr2 !== EXP_ERR) begin errors++; $error("FAIL perr_sticky2: observed=%h expected=%h", perr2, EXP_ERR); end
    checks++; if (perr3 !== EXP_ERR) begin errors++; $error("FAIL perr_sticky3: observed=%h expected=%h", perr3, EXP_ERR); end
    reset = 1'b0;
    tick();
    checks++; if (perr2 !== 1'b0) begin errors++; $error("FAIL perr_cleared: observed=%h expected=%h", perr2, 1'b0); end
    checks++; if (cnt2 !== 32'd0) begin errors++; $error("FAIL rst2_cnt: observed=%h expected=%h", cnt2, 32'd0); end
    checks++; if (dq2 !== 16'hzzzz) begin errors++; $error("FAIL rst2_dq_z: observed=%h expected=%h", dq2, 16'hzzzz); end
    reset = 1'b1;
    tick();

    wr(18'h00005, 16'h0000, 1'b1, 1'b1);
    checks++; if (cnt2 !== 32'd1) begin errors++; $error("FAIL nolane_cnt: observed=%h expected=%h", cnt2, 32'd1); end
    checks++; if (perr2 !== EXP_ERR) begin errors++; $error("FAIL nolane_perr: observed=%h expected=%h", perr2, EXP_ERR); end
    rd(18'h00005);
    tick(); tick();
    checks++; if (dq2 !== 16'hCAFE) begin errors++; $error("FAIL nolane_data: observed=%h expected=%h", dq2, 16'hCAFE); end
    checks++; if (cnt2 !== 32'd2) begin errors++; $error("FAIL nolane_rd_cnt: observed=%h expected=%h", cnt2, 32'd2); end
    idle();
    tick();
    rd(18'h00009);
    tick(); tick();
    checks++; if (dq2 !== 16'h5555) begin errors++; $error("FAIL illegal_wr_data: observed=%h expected=%h", dq2, 16'h5555); end
    checks++; if (cnt2 !== 32'd3) begin errors++; $error("FAIL illegal_wr_cnt: observed=%h expected=%h", cnt2, 32'd3); end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
